// File: rtl/traffic_light_monitor_if.sv
// Lamp and status bundle between an intersection controller and its passive monitor.
// The monitor side only ever reads the street lamps.
interface traffic_light_monitor_if;
    logic [2:0]  street_a;
    logic [2:0]  street_b;
    logic        err_pulse;
    logic        err_sticky;
    logic [2:0]  err_code;
    logic [15:0] phase_cnt;

    modport master (
        output street_a, street_b,
        input  err_pulse, err_sticky, err_code, phase_cnt
    );

    modport slave (
        input  street_a, street_b,
        output err_pulse, err_sticky, err_code, phase_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-street traffic light: lamp encoding, sequencing,
// hold timing and green/yellow conflicts, plus a count of completed street-A cycles.
module traffic_light_monitor #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_light_monitor_if.slave  bus
);

    typedef enum logic [1:0] {SYNC, RED, GREEN, YELLOW} state_t;

    localparam logic [15:0] GREEN_HOLD  = 16'(GREEN_CYC);
    localparam logic [15:0] YELLOW_HOLD = 16'(YELLOW_CYC);

    logic [2:0]  lamp       [2];
    logic [2:0]  prev_q     [2];
    logic [15:0] hold_q     [2];
    logic [15:0] hold_d     [2];
    state_t      state_q    [2];
    state_t      state_d    [2];
    logic        from_sync_q[2];
    logic        from_sync_d[2];
    logic        enc_err    [2];
    logic        seq_err    [2];
    logic        tim_err    [2];

    logic        conflict;
    logic        any_err;
    logic        phase_inc;
    logic [2:0]  code_d;

    assign lamp[0] = bus.street_a;
    assign lamp[1] = bus.street_b;

    function automatic state_t decode(input logic [2:0] v);
        case (v)
            3'b100:  decode = RED;
            3'b010:  decode = YELLOW;
            3'b001:  decode = GREEN;
            default: decode = SYNC;
        endcase
    endfunction

    function automatic logic is_go(input logic [2:0] v);
        is_go = (v == 3'b001) || (v == 3'b010);
    endfunction

    // Per-street checking; an illegal encoding freezes that street's FSM and hold
    // counter, while values seen during SYNC are never reported as encoding errors.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i]     = state_q[i];
            hold_d[i]      = hold_q[i];
            from_sync_d[i] = from_sync_q[i];
            enc_err[i]     = 1'b0;
            seq_err[i]     = 1'b0;
            tim_err[i]     = 1'b0;
            if (!$onehot(lamp[i])) begin
                enc_err[i] = (state_q[i] != SYNC);
            end else begin
                if (lamp[i] != prev_q[i])
                    hold_d[i] = 16'd1;
                else if (hold_q[i] != 16'hFFFF)
                    hold_d[i] = hold_q[i] + 16'd1;
                state_d[i] = decode(lamp[i]);
                if (state_q[i] == SYNC) begin
                    from_sync_d[i] = 1'b1;
                end else if (state_d[i] != state_q[i]) begin
                    from_sync_d[i] = 1'b0;
                    seq_err[i] = !((state_q[i] == RED    && state_d[i] == GREEN)  ||
                                   (state_q[i] == GREEN  && state_d[i] == YELLOW) ||
                                   (state_q[i] == YELLOW && state_d[i] == RED));
                    if (!from_sync_q[i]) begin
                        if (state_q[i] == GREEN && hold_q[i] != GREEN_HOLD)
                            tim_err[i] = 1'b1;
                        if (state_q[i] == YELLOW && hold_q[i] != YELLOW_HOLD)
                            tim_err[i] = 1'b1;
                    end
                end
            end
        end
    end

    // Lowest code wins when several violations land on the same edge.
    always_comb begin
        conflict  = is_go(lamp[0]) && is_go(lamp[1]);
        any_err   = conflict || enc_err[0] || enc_err[1] || seq_err[0] ||
                    seq_err[1] || tim_err[0] || tim_err[1];
        phase_inc = (state_q[0] == YELLOW) && !from_sync_q[0] && (lamp[0] == 3'b100);
        code_d    = 3'd0;
        if (conflict)        code_d = 3'd1;
        else if (enc_err[0]) code_d = 3'd2;
        else if (enc_err[1]) code_d = 3'd3;
        else if (seq_err[0]) code_d = 3'd4;
        else if (seq_err[1]) code_d = 3'd5;
        else if (tim_err[0]) code_d = 3'd6;
        else if (tim_err[1]) code_d = 3'd7;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i]      <= 3'b000;
                hold_q[i]      <= 16'd0;
                state_q[i]     <= SYNC;
                from_sync_q[i] <= 1'b0;
            end
            bus.err_pulse  <= 1'b0;
            bus.err_sticky <= 1'b0;
            bus.err_code   <= 3'd0;
            bus.phase_cnt  <= 16'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                prev_q[i]      <= lamp[i];
                hold_q[i]      <= hold_d[i];
                state_q[i]     <= state_d[i];
                from_sync_q[i] <= from_sync_d[i];
            end
            bus.err_pulse <= any_err;
            if (any_err)
                bus.err_sticky <= 1'b1;
            if (any_err && !bus.err_sticky)
                bus.err_code <= code_d;
            if (phase_inc && bus.phase_cnt != 16'hFFFF)
                bus.phase_cnt <= bus.phase_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scenarios for traffic_light_monitor with GREEN_CYC = 3, YELLOW_CYC = 1.
module tb_traffic_light_monitor;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;

    traffic_light_monitor_if bus ();

    traffic_light_monitor #(.GREEN_CYC(3), .YELLOW_CYC(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one lamp pair, let it be sampled, then look just after the edge.
    task automatic step(input logic [2:0] a, input logic [2:0] b);
        bus.street_a = a;
        bus.street_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.street_a = LR;
        bus.street_b = LR;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (bus.err_pulse !== 1'b0)  $display("[TB] FAIL reset_pulse: got %0d expected 0", bus.err_pulse); else passed++;
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL reset_sticky: got %0d expected 0", bus.err_sticky); else passed++;
        total++; if (bus.err_code !== 3'd0)   $display("[TB] FAIL reset_code: got %0d expected 0", bus.err_code); else passed++;
        total++; if (bus.phase_cnt !== 16'd0) $display("[TB] FAIL reset_phase: got %0d expected 0", bus.phase_cnt); else passed++;
    endtask

    task automatic test_normal_cycle();
        do_reset();
        step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR);
        total++; if (bus.phase_cnt !== 16'd0) $display("[TB] FAIL cycle_phase_before_red: got %0d expected 0", bus.phase_cnt); else passed++;
        step(LR, LR);
        total++; if (bus.phase_cnt !== 16'd1) $display("[TB] FAIL cycle_phase_first: got %0d expected 1", bus.phase_cnt); else passed++;
        step(LR, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR); step(LR, LR);
        total++; if (bus.phase_cnt !== 16'd2) $display("[TB] FAIL cycle_phase_second: got %0d expected 2", bus.phase_cnt); else passed++;
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL cycle_sticky: got %0d expected 0", bus.err_sticky); else passed++;
    endtask

    task automatic test_conflict();
        do_reset();
        step(LR, LR); step(LR, LG);
        total++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL conflict_before: got %0d expected 0", bus.err_pulse); else passed++;
        step(LY, LG);
        total++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL conflict_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        total++; if (bus.err_code !== 3'd1)  $display("[TB] FAIL conflict_code: got %0d expected 1", bus.err_code); else passed++;
        // B leaves green after 2 cycles: timing-B pulse, first code kept, A cycle counted.
        step(LR, LY);
        total++; if (bus.err_pulse !== 1'b1)  $display("[TB] FAIL conflict_later_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        total++; if (bus.err_code !== 3'd1)   $display("[TB] FAIL conflict_code_kept: got %0d expected 1", bus.err_code); else passed++;
        total++; if (bus.phase_cnt !== 16'd1) $display("[TB] FAIL conflict_phase: got %0d expected 1", bus.phase_cnt); else passed++;
    endtask

    task automatic test_encoding();
        do_reset();
        step(LR, LR); step(LR, LR); step(3'b110, LR);
        total++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL enc_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        total++; if (bus.err_code !== 3'd2)  $display("[TB] FAIL enc_code: got %0d expected 2", bus.err_code); else passed++;
        step(LR, LR);
        total++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL enc_next_red: got %0d expected 0", bus.err_pulse); else passed++;
        step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR);
        total++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL enc_then_yellow: got %0d expected 0", bus.err_pulse); else passed++;
        check("enc_code_held", int'(bus.err_code), 2);
    endtask

    task automatic test_sequence();
        do_reset();
        step(LR, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LR, LR);
        total++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL seq_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        total++; if (bus.err_code !== 3'd4)  $display("[TB] FAIL seq_code: got %0d expected 4", bus.err_code); else passed++;
        step(LR, LR);
        total++; if (bus.err_pulse !== 1'b0) $display("[TB] FAIL seq_pulse_drop: got %0d expected 0", bus.err_pulse); else passed++;
        step(LG, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR);
        total++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL seq_timing_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        total++; if (bus.err_code !== 3'd4)  $display("[TB] FAIL seq_code_kept: got %0d expected 4", bus.err_code); else passed++;
    endtask

    task automatic test_timing();
        do_reset();
        step(LR, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR);
        total++; if (bus.err_code !== 3'd6)  $display("[TB] FAIL timing_code: got %0d expected 6", bus.err_code); else passed++;
        total++; if (bus.err_pulse !== 1'b1) $display("[TB] FAIL timing_pulse: got %0d expected 1", bus.err_pulse); else passed++;
        do_reset();
        step(LG, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LG, LR); step(LY, LR);
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL timing_sync_exempt: got %0d expected 0", bus.err_sticky); else passed++;
        step(LR, LR);
        total++; if (bus.phase_cnt !== 16'd1) $display("[TB] FAIL timing_sync_phase: got %0d expected 1", bus.phase_cnt); else passed++;
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL timing_sync_red: got %0d expected 0", bus.err_sticky); else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step(LR, LR); step(LG, LR); step(LR, LR); step(LG, LR);
        total++; if (bus.err_sticky !== 1'b1) $display("[TB] FAIL async_pre_sticky: got %0d expected 1", bus.err_sticky); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL async_sticky: got %0d expected 0", bus.err_sticky); else passed++;
        total++; if (bus.err_code !== 3'd0)   $display("[TB] FAIL async_code: got %0d expected 0", bus.err_code); else passed++;
        total++; if (bus.err_pulse !== 1'b0)  $display("[TB] FAIL async_pulse: got %0d expected 0", bus.err_pulse); else passed++;
        total++; if (bus.phase_cnt !== 16'd0) $display("[TB] FAIL async_phase: got %0d expected 0", bus.phase_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step(LR, LG);
        total++; if (bus.err_pulse !== 1'b0)  $display("[TB] FAIL async_first_b_green: got %0d expected 0", bus.err_pulse); else passed++;
        step(LR, LG);
        total++; if (bus.err_sticky !== 1'b0) $display("[TB] FAIL async_after_release: got %0d expected 0", bus.err_sticky); else passed++;
    endtask

    initial begin
        bus.street_a = LR;
        bus.street_b = LR;
        test_reset();
        test_normal_cycle();
        test_conflict();
        test_encoding();
        test_sequence();
        test_timing();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

endmodule
